ethernet_rule_filter: RTL and testbench

Parametrised, programmable successor to the single-rule Ethernet header filter. It holds a table of NUM_RULES masked match rules, written at runtime through a config port. Each header offered on a valid/ready stream is classified against the table in a 2-stage pipeline: the lowest-index enabled matching rule wins, otherwise DEFAULT_PASS applies. Each rule has a saturating hit counter readable through the config port. The block sits in the RX application path between header extraction and the pass/drop stage.

---
 rtl/ethernet_rule_filter.sv | 143 ++++++++++++++
 tb/tb_ethernet_rule_filter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_rule_filter.sv
// Programmable Ethernet header classifier with NUM_RULES masked match rules.
// Two-stage valid/ready pipeline: S1 holds the per-rule match vector, S2 holds
// the priority-encoded verdict. Each rule has a saturating hit counter.
module ethernet_rule_filter #(
  parameter int unsigned HDR_W        = 112,
  parameter int unsigned NUM_RULES    = 8,
  parameter int unsigned IDX_W        = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1,
  parameter int unsigned CNT_W        = 32,
  parameter bit          DEFAULT_PASS = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             hdr_valid_i,
  output logic             hdr_ready_o,
  input  logic [HDR_W-1:0] hdr_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             res_pass_o,
  output logic             res_hit_o,
  output logic [IDX_W-1:0] res_idx_o,
  input  logic             cfg_wr_en_i,
  input  logic [IDX_W-1:0] cfg_addr_i,
  input  logic [HDR_W-1:0] cfg_value_i,
  input  logic [HDR_W-1:0] cfg_mask_i,
  input  logic             cfg_enable_i,
  input  logic [IDX_W-1:0] cfg_rd_addr_i,
  output logic [CNT_W-1:0] cfg_rd_data_o,
  input  logic             cnt_clr_i
);

  logic [HDR_W-1:0]     rule_value_q [NUM_RULES];
  logic [HDR_W-1:0]     rule_mask_q  [NUM_RULES];
  logic [NUM_RULES-1:0] rule_en_q;
  logic [NUM_RULES-1:0] match_vec;

  logic                 s1_valid_q;
  logic [NUM_RULES-1:0] s1_match_q;
  logic                 s2_valid_q;
  logic                 res_pass_q, res_hit_q;
  logic [IDX_W-1:0]     res_idx_q;

  logic                 hit_d, pass_d;
  logic [IDX_W-1:0]     idx_d;
  logic                 adv, cnt_inc;
  logic                 wr_in_range, rd_in_range;

  logic [CNT_W-1:0]     cnt_q [NUM_RULES];
  logic [CNT_W-1:0]     rd_data_q;

  // Full-stall pipeline: everything advances together or holds.
  assign adv         = !s2_valid_q || res_ready_i;
  assign hdr_ready_o = adv;
  assign wr_in_range = 32'(cfg_addr_i) < NUM_RULES;
  assign rd_in_range = 32'(cfg_rd_addr_i) < NUM_RULES;
  assign cnt_inc     = adv && s1_valid_q && hit_d;

  // Rule table; writes beyond the last slot are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rule_en_q <= '0;
      for (int i = 0; i < int'(NUM_RULES); i++) begin
        rule_value_q[i] <= '0;
        rule_mask_q[i]  <= '0;
      end
    end else if (cfg_wr_en_i && wr_in_range) begin
      rule_value_q[cfg_addr_i] <= cfg_value_i;
      rule_mask_q[cfg_addr_i]  <= cfg_mask_i;
      rule_en_q[cfg_addr_i]    <= cfg_enable_i;
    end
  end

  // Per-rule masked compare against the table as it stands before the edge.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < int'(NUM_RULES); i++) begin
      match_vec[i] = rule_en_q[i] && (((hdr_i ^ rule_value_q[i]) & rule_mask_q[i]) == '0);
    end
  end

  // Priority encode S1: scanning downwards leaves the lowest matching index.
  always_comb begin
    hit_d = 1'b0;
    idx_d = '0;
    for (int i = int'(NUM_RULES) - 1; i >= 0; i--) begin
      if (s1_match_q[i]) begin
        hit_d = 1'b1;
        idx_d = IDX_W'(i);
      end
    end
    pass_d = hit_d | DEFAULT_PASS;
  end

  // S1 and S2 pipeline registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_match_q <= '0;
      s2_valid_q <= 1'b0;
      res_pass_q <= 1'b0;
      res_hit_q  <= 1'b0;
      res_idx_q  <= '0;
    end else if (adv) begin
      s1_valid_q <= hdr_valid_i;
      // Empty slots carry no match so an idle S2 shows a clean zero result.
      s1_match_q <= hdr_valid_i ? match_vec : '0;
      s2_valid_q <= s1_valid_q;
      res_pass_q <= pass_d;
      res_hit_q  <= hit_d;
      res_idx_q  <= idx_d;
    end
  end

  // Saturating hit counters; a clear overrides a coincident increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NUM_RULES); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_RULES); i++) begin
        if (cnt_clr_i) begin
          cnt_q[i] <= '0;
        end else if (cnt_inc && (idx_d == IDX_W'(i)) && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Registered counter read port; shows the value before this edge's update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_in_range ? cnt_q[cfg_rd_addr_i] : '0;
    end
  end

  assign res_valid_o   = s2_valid_q;
  assign res_pass_o    = res_pass_q;
  assign res_hit_o     = res_hit_q;
  assign res_idx_o     = res_idx_q;
  assign cfg_rd_data_o = rd_data_q;

endmodule

// File: tb/tb_ethernet_rule_filter.sv
// Self-checking bench for ethernet_rule_filter: a rule-table model predicts each
// verdict at accept time into a scoreboard that the output monitor drains.
module tb_ethernet_rule_filter;

  localparam int NR = 6;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         hdr_valid_i;
  logic         hdr_ready_o;
  logic [111:0] hdr_i;
  logic         res_valid_o;
  logic         res_ready_i;
  logic         res_pass_o;
  logic         res_hit_o;
  logic [2:0]   res_idx_o;
  logic         cfg_wr_en_i;
  logic [2:0]   cfg_addr_i;
  logic [111:0] cfg_value_i;
  logic [111:0] cfg_mask_i;
  logic         cfg_enable_i;
  logic [2:0]   cfg_rd_addr_i;
  logic [3:0]   cfg_rd_data_o;
  logic         cnt_clr_i;

  ethernet_rule_filter #(
    .HDR_W       (112),
    .NUM_RULES   (NR),
    .IDX_W       (3),
    .CNT_W       (4),
    .DEFAULT_PASS(1'b0)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .hdr_valid_i  (hdr_valid_i),
    .hdr_ready_o  (hdr_ready_o),
    .hdr_i        (hdr_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_pass_o   (res_pass_o),
    .res_hit_o    (res_hit_o),
    .res_idx_o    (res_idx_o),
    .cfg_wr_en_i  (cfg_wr_en_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_value_i  (cfg_value_i),
    .cfg_mask_i   (cfg_mask_i),
    .cfg_enable_i (cfg_enable_i),
    .cfg_rd_addr_i(cfg_rd_addr_i),
    .cfg_rd_data_o(cfg_rd_data_o),
    .cnt_clr_i    (cnt_clr_i)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [111:0] HBcast = {16'h0800, 48'h001122334455, 48'hFFFFFFFFFFFF};
  localparam logic [111:0] HUni4  = {16'h0800, 48'h001122334455, 48'h020000000001};
  localparam logic [111:0] HUni6  = {16'h86DD, 48'hAABBCCDDEEFF, 48'h0A0B0C0D0E0F};
  localparam logic [111:0] HLldp  = {16'h88CC, 48'h001122334455, 48'h0180C200000E};

  // Reference model of the rule table and counters.
  logic [111:0] m_val  [NR];
  logic [111:0] m_mask [NR];
  logic         m_en   [NR];
  int           m_cnt  [NR];
  logic [4:0]   sb [$];   // {pass, hit, idx}

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  saw_stall;
  bit  prev_stall = 1'b0;
  logic [5:0] prev_res;

  function automatic logic [4:0] model_res(input logic [111:0] h);
    for (int i = 0; i < NR; i++) begin
      if (m_en[i] && (((h ^ m_val[i]) & m_mask[i]) == '0)) return {1'b1, 1'b1, 3'(i)};
    end
    return 5'b00000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_val[i] = '0; m_mask[i] = '0; m_en[i] = 1'b0; m_cnt[i] = 0;
    end
    sb.delete();
  endtask

  // Output monitor: pops the scoreboard on each handshake, checks hold during stall.
  always @(negedge clk_i) begin
    logic [5:0] cur;
    logic [4:0] e;
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      cur = {res_valid_o, res_pass_o, res_hit_o, res_idx_o};
      if (prev_stall) begin
        n_checks++;
        if (cur !== prev_res) $display("FAIL stall_hold: got %b required %b", cur, prev_res);
        else n_pass++;
      end
      if (res_valid_o && res_ready_i) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL result_unexpected: got %b with no result outstanding", cur[4:0]);
        end else begin
          e = sb.pop_front();
          if (cur[4:0] !== e) $display("FAIL result: got %b required %b", cur[4:0], e);
          else n_pass++;
        end
      end
      prev_stall = res_valid_o && !res_ready_i;
      prev_res   = cur;
    end
  end

  task automatic cfg_write(input logic [2:0] a, input logic [111:0] v, input logic [111:0] m,
                           input logic en);
    cfg_addr_i = a; cfg_value_i = v; cfg_mask_i = m; cfg_enable_i = en; cfg_wr_en_i = 1'b1;
    @(posedge clk_i); #1;
    cfg_wr_en_i = 1'b0;
    if (int'(a) < NR) begin
      m_val[a] = v; m_mask[a] = m; m_en[a] = en;
    end
  endtask

  task automatic send_hdr(input logic [111:0] h, input bit keep);
    bit acc;
    logic [4:0] e;
    acc = 1'b0;
    hdr_i = h;
    hdr_valid_i = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk_i);
      if (hdr_ready_o) begin
        acc = 1'b1;
        e = model_res(h);
        sb.push_back(e);
        if (e[3] && m_cnt[e[2:0]] < 15) m_cnt[e[2:0]]++;
      end else begin
        saw_stall = 1'b1;
        @(posedge clk_i);
      end
    end
    if (!acc) begin
      n_checks++;
      $display("FAIL hdr_accept_timeout: hdr_ready 0 for 50 cycles, required 1");
    end else begin
      @(posedge clk_i); #1;
    end
    if (!keep) hdr_valid_i = 1'b0;
  endtask

  task automatic read_cnt(input logic [2:0] a, output logic [3:0] v);
    cfg_rd_addr_i = a;
    @(posedge clk_i);
    @(negedge clk_i);
    v = cfg_rd_data_o;
    @(posedge clk_i); #1;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk_i);
    #1;
    n_checks++;
    if (sb.size() != 0) $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [3:0] v;
    @(negedge clk_i);
    n_checks++;
    if ({res_valid_o, res_pass_o, res_hit_o, res_idx_o, cfg_rd_data_o, hdr_ready_o} !== 11'b1)
      $display("FAIL reset_outputs: got v%b p%b h%b i%0d rd%0d rdy%b required 0 0 0 0 0 1",
               res_valid_o, res_pass_o, res_hit_o, res_idx_o, cfg_rd_data_o, hdr_ready_o);
    else n_pass++;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    res_ready_i = 1'b1;
    send_hdr(HBcast, 1'b0);
    @(negedge clk_i);
    n_checks++;
    if (res_valid_o !== 1'b0) $display("FAIL latency_early: res_valid %b required 0", res_valid_o);
    else n_pass++;
    @(negedge clk_i);
    n_checks++;
    if (res_valid_o !== 1'b1) $display("FAIL latency: res_valid %b required 1", res_valid_o);
    else n_pass++;
    @(posedge clk_i); #1;
    wait_drain();
    for (int a = 0; a < NR; a++) begin
      read_cnt(3'(a), v);
      n_checks++;
      if (v !== 4'd0) $display("FAIL reset_cnt%0d: got %0d required 0", a, v);
      else n_pass++;
    end
  endtask

  task automatic test_out_of_range();
    cfg_write(3'd7, '0, '0, 1'b1);
    cfg_write(3'd6, '0, '0, 1'b1);
    send_hdr(HUni6, 1'b0);
    wait_drain();
  endtask

  task automatic test_priority();
    logic [3:0] v;
    cfg_write(3'd2, {64'h0, 48'hFFFFFFFFFFFF}, {64'h0, {48{1'b1}}}, 1'b1);
    cfg_write(3'd5, {16'h0800, 96'h0}, {16'hFFFF, 96'h0}, 1'b1);
    send_hdr(HBcast, 1'b1);
    send_hdr(HUni4, 1'b1);
    send_hdr(HUni6, 1'b0);
    wait_drain();
    for (int a = 2; a <= 5; a += 3) begin
      read_cnt(3'(a), v);
      n_checks++;
      if (v !== 4'(m_cnt[a])) $display("FAIL prio_cnt%0d: got %0d required %0d", a, v, m_cnt[a]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] b2, b5, a2, a5;
    read_cnt(3'd2, b2);
    read_cnt(3'd5, b5);
    saw_stall = 1'b0;
    res_ready_i = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_hdr((i % 2 == 0) ? HBcast : HUni4, 1'b1);
        hdr_valid_i = 1'b0;
      end
      begin
        repeat (4) @(posedge clk_i);
        #1 res_ready_i = 1'b1;
      end
    join
    n_checks++;
    if (saw_stall !== 1'b1) $display("FAIL bp_stall: hdr_ready never 0, required a stall");
    else n_pass++;
    wait_drain();
    read_cnt(3'd2, a2);
    read_cnt(3'd5, a5);
    n_checks++;
    if ((int'(a2) + int'(a5)) - (int'(b2) + int'(b5)) != 6)
      $display("FAIL bp_hits: got %0d required 6", (int'(a2) + int'(a5)) - (int'(b2) + int'(b5)));
    else n_pass++;
  endtask

  task automatic test_cfg_race();
    logic [3:0] v;
    cfg_addr_i = 3'd0; cfg_value_i = HUni6; cfg_mask_i = '1; cfg_enable_i = 1'b1;
    cfg_wr_en_i = 1'b1;
    hdr_i = HUni6; hdr_valid_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (hdr_ready_o !== 1'b1) $display("FAIL race_ready: got %b required 1", hdr_ready_o);
    else n_pass++;
    sb.push_back(model_res(HUni6));  // table not yet updated: no hit
    @(posedge clk_i); #1;
    hdr_valid_i = 1'b0; cfg_wr_en_i = 1'b0;
    m_val[0] = HUni6; m_mask[0] = '1; m_en[0] = 1'b1;
    send_hdr(HUni6, 1'b0);
    wait_drain();
    read_cnt(3'd0, v);
    n_checks++;
    if (v !== 4'd1) $display("FAIL race_cnt0: got %0d required 1", v);
    else n_pass++;
  endtask

  task automatic test_counters();
    logic [3:0] v;
    cfg_write(3'd0, '0, '0, 1'b0);
    cfg_write(3'd1, '0, '0, 1'b1);
    for (int i = 0; i < 20; i++) send_hdr(HUni6, 1'b1);
    hdr_valid_i = 1'b0;
    wait_drain();
    read_cnt(3'd1, v);
    n_checks++;
    if (v !== 4'd15) $display("FAIL cnt_saturate: got %0d required 15", v);
    else n_pass++;
    read_cnt(3'd6, v);
    n_checks++;
    if (v !== 4'd0) $display("FAIL cnt_oob_read: got %0d required 0", v);
    else n_pass++;
    // Plain clear, then two hits.
    cnt_clr_i = 1'b1;
    @(posedge clk_i); #1;
    cnt_clr_i = 1'b0;
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    read_cnt(3'd1, v);
    n_checks++;
    if (v !== 4'd0) $display("FAIL cnt_clear: got %0d required 0", v);
    else n_pass++;
    send_hdr(HUni6, 1'b1);
    send_hdr(HUni6, 1'b0);
    wait_drain();
    read_cnt(3'd1, v);
    n_checks++;
    if (v !== 4'd2) $display("FAIL cnt_two: got %0d required 2", v);
    else n_pass++;
    // Clear coinciding with the edge the next hit enters S2.
    send_hdr(HUni6, 1'b0);
    cnt_clr_i = 1'b1;
    @(posedge clk_i); #1;
    cnt_clr_i = 1'b0;
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    @(negedge clk_i);
    n_checks++;
    if (cfg_rd_data_o !== 4'd2) $display("FAIL cnt_pre_inc: got %0d required 2", cfg_rd_data_o);
    else n_pass++;
    @(negedge clk_i);
    n_checks++;
    if (cfg_rd_data_o !== 4'd0) $display("FAIL cnt_clr_wins: got %0d required 0", cfg_rd_data_o);
    else n_pass++;
    @(posedge clk_i); #1;
    wait_drain();
  endtask

  task automatic test_async_reset();
    logic [3:0] v;
    res_ready_i = 1'b0;
    send_hdr(HBcast, 1'b0);
    send_hdr(HUni4, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    n_checks++;
    if (res_valid_o !== 1'b0 || hdr_ready_o !== 1'b1)
      $display("FAIL async_reset: res_valid %b hdr_ready %b required 0 1", res_valid_o, hdr_ready_o);
    else n_pass++;
    model_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    res_ready_i = 1'b1;
    cfg_write(3'd3, {16'h88CC, 96'h0}, {16'hFFFF, 96'h0}, 1'b1);
    send_hdr(HLldp, 1'b0);
    @(negedge clk_i);
    n_checks++;
    if (res_valid_o !== 1'b0) $display("FAIL rst_latency_early: res_valid %b required 0", res_valid_o);
    else n_pass++;
    @(negedge clk_i);
    n_checks++;
    if (res_valid_o !== 1'b1) $display("FAIL rst_latency: res_valid %b required 1", res_valid_o);
    else n_pass++;
    @(posedge clk_i); #1;
    send_hdr(HBcast, 1'b0);
    wait_drain();
    read_cnt(3'd3, v);
    n_checks++;
    if (v !== 4'd1) $display("FAIL rst_cnt3: got %0d required 1", v);
    else n_pass++;
    read_cnt(3'd2, v);
    n_checks++;
    if (v !== 4'd0) $display("FAIL rst_cnt2: got %0d required 0", v);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    hdr_valid_i = 1'b0; hdr_i = '0; res_ready_i = 1'b0;
    cfg_wr_en_i = 1'b0; cfg_addr_i = '0; cfg_value_i = '0; cfg_mask_i = '0;
    cfg_enable_i = 1'b0; cfg_rd_addr_i = '0; cnt_clr_i = 1'b0;
    model_reset();
    test_reset();
    test_out_of_range();
    test_priority();
    test_back_to_back();
    test_cfg_race();
    test_counters();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
